// File: rtl/dct_pkg.sv
// -----------------------------------------------------------------------------
// dct_pkg
// Shared constants for the 4x4 two-dimensional DCT:
//   - BUF_W    : width of the transpose-buffer entries (stage-1 results)
//   - C64/C83/C36 : integer DCT basis coefficients
//   - DEF_SHIFT_* : default rounding shifts for forward / inverse stages
//   - state_t  : block controller states (FILL collects rows, DRAIN emits columns)
// No ports (package).
// -----------------------------------------------------------------------------
package dct_pkg;

    localparam int BUF_W  = 16;
    localparam int COEF_W = 8;

    localparam logic signed [COEF_W-1:0] C64 = 8'sd64;
    localparam logic signed [COEF_W-1:0] C83 = 8'sd83;
    localparam logic signed [COEF_W-1:0] C36 = 8'sd36;

    localparam int DEF_SHIFT_F1 = 1;
    localparam int DEF_SHIFT_F2 = 8;
    localparam int DEF_SHIFT_I1 = 7;
    localparam int DEF_SHIFT_I2 = 12;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/dct4_1d.sv
// -----------------------------------------------------------------------------
// dct4_1d
// Combinational 4-point integer DCT butterfly, forward or inverse.
// Outputs are the full-precision sums (IN_W+9 bits), before any rounding.
// Ports:
//   inv         : 0 = forward transform, 1 = inverse transform
//   x0..x3      : signed input vector, IN_W bits each
//   y0..y3      : signed unrounded result, IN_W+9 bits each
// -----------------------------------------------------------------------------
module dct4_1d
    import dct_pkg::*;
#(
    parameter int IN_W = 16
) (
    input  logic                   inv,
    input  logic signed [IN_W-1:0] x0,
    input  logic signed [IN_W-1:0] x1,
    input  logic signed [IN_W-1:0] x2,
    input  logic signed [IN_W-1:0] x3,
    output logic signed [IN_W+8:0] y0,
    output logic signed [IN_W+8:0] y1,
    output logic signed [IN_W+8:0] y2,
    output logic signed [IN_W+8:0] y3
);

    localparam int OUT_W = IN_W + 9;

    // Coefficients widened so every product is evaluated at the full sum width.
    localparam logic signed [OUT_W-1:0] K64 = OUT_W'(C64);
    localparam logic signed [OUT_W-1:0] K83 = OUT_W'(C83);
    localparam logic signed [OUT_W-1:0] K36 = OUT_W'(C36);

    logic signed [OUT_W-1:0] e0, e1, e2, e3;
    logic signed [OUT_W-1:0] a0, a1, b0, b1;
    logic signed [OUT_W-1:0] ev0, ev1, od0, od1;

    always_comb begin
        e0 = OUT_W'(x0);
        e1 = OUT_W'(x1);
        e2 = OUT_W'(x2);
        e3 = OUT_W'(x3);

        // Forward butterflies
        a0 = e0 + e3;
        a1 = e1 + e2;
        b0 = e0 - e3;
        b1 = e1 - e2;

        // Inverse even/odd parts
        ev0 = K64 * (e0 + e2);
        ev1 = K64 * (e0 - e2);
        od0 = K83 * e1 + K36 * e3;
        od1 = K36 * e1 - K83 * e3;

        if (inv) begin
            y0 = ev0 + od0;
            y1 = ev1 + od1;
            y2 = ev1 - od1;
            y3 = ev0 - od0;
        end else begin
            y0 = K64 * a0 + K64 * a1;
            y1 = K83 * b0 + K36 * b1;
            y2 = K64 * a0 - K64 * a1;
            y3 = K36 * b0 - K83 * b1;
        end
    end

endmodule

// File: rtl/dct4_2d.sv
// -----------------------------------------------------------------------------
// dct4_2d
// 4x4 separable integer DCT (forward or inverse). Rows arrive one per beat,
// pass through the row transform into a transpose buffer; once four rows are
// in, the columns are transformed and emitted one per beat.
// Ports:
//   clk, rst_b            : clock, asynchronous active-low reset
//   in_valid / in_ready   : input row handshake
//   inv                   : transform direction, taken from row 0 of a block
//   x0..x3                : input row (WIDTH_X signed)
//   out_valid / out_ready : output column handshake
//   y0..y3                : output column (WIDTH_Y signed), y0 = row 0
// -----------------------------------------------------------------------------
module dct4_2d
    import dct_pkg::*;
#(
    parameter int WIDTH_X  = 16,
    parameter int WIDTH_Y  = 16,
    parameter int SHIFT_F1 = DEF_SHIFT_F1,
    parameter int SHIFT_F2 = DEF_SHIFT_F2,
    parameter int SHIFT_I1 = DEF_SHIFT_I1,
    parameter int SHIFT_I2 = DEF_SHIFT_I2
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      inv,
    input  logic signed [WIDTH_X-1:0] x0,
    input  logic signed [WIDTH_X-1:0] x1,
    input  logic signed [WIDTH_X-1:0] x2,
    input  logic signed [WIDTH_X-1:0] x3,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [WIDTH_Y-1:0] y0,
    output logic signed [WIDTH_Y-1:0] y1,
    output logic signed [WIDTH_Y-1:0] y2,
    output logic signed [WIDTH_Y-1:0] y3
);

    localparam int S1_W  = WIDTH_X + 9;
    localparam int S2_W  = BUF_W + 9;
    localparam int SUM_W = (S1_W > S2_W) ? S1_W : S2_W;
    // One guard bit so adding the rounding bias can never wrap.
    localparam int EXT_W = SUM_W + 1;

    typedef logic signed [EXT_W-1:0] ext_t;

    // (v + 2^(s-1)) >>> s, arithmetic (floor) shift.
    function automatic ext_t round_shift(input ext_t v, input int s);
        ext_t one;
        one    = '0;
        one[0] = 1'b1;
        if (s <= 0) return v;
        return (v + (one <<< (s - 1))) >>> s;
    endfunction

    // Clamp to the signed range of a w-bit value.
    function automatic ext_t saturate(input ext_t v, input int w);
        ext_t one, hi, lo;
        one    = '0;
        one[0] = 1'b1;
        hi     = (one <<< (w - 1)) - one;
        lo     = -hi - one;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    state_t state, state_nxt;

    logic [1:0] row;
    logic [1:0] col;
    logic       mode;
    logic       in_fire;
    logic       out_fire;
    logic       s1_inv;
    int         sh1;
    int         sh2;
    logic [1:0] s2_sel;

    logic signed [BUF_W-1:0]   tbuf   [4][4];
    logic signed [WIDTH_Y-1:0] yreg   [4];
    logic signed [S1_W-1:0]    s1_raw [4];
    logic signed [BUF_W-1:0]   s1_val [4];
    logic signed [BUF_W-1:0]   s2_in  [4];
    logic signed [S2_W-1:0]    s2_raw [4];
    logic signed [WIDTH_Y-1:0] s2_val [4];

    // ---------------- Controller ----------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= FILL;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && row == 2'd3) state_nxt = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && col == 2'd3) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // ---------------- Stage 1: row transform ----------------
    // Row 0 uses the live inv input; later rows reuse the mode captured then.
    assign s1_inv = (row == 2'd0) ? inv : mode;
    assign sh1    = s1_inv ? SHIFT_I1 : SHIFT_F1;

    dct4_1d #(.IN_W(WIDTH_X)) u_stage1 (
        .inv (s1_inv),
        .x0  (x0),
        .x1  (x1),
        .x2  (x2),
        .x3  (x3),
        .y0  (s1_raw[0]),
        .y1  (s1_raw[1]),
        .y2  (s1_raw[2]),
        .y3  (s1_raw[3])
    );

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            s1_val[i] = BUF_W'(saturate(round_shift(EXT_W'(s1_raw[i]), sh1), BUF_W));
        end
    end

    // ---------------- Stage 2: column transform ----------------
    // While filling, column 0 is prepared from the row being accepted now
    // (bypassing the buffer for row 3) so it can be loaded on that same edge.
    // While draining, the next column is prepared ahead of the handshake.
    assign s2_sel = (state == FILL) ? 2'd0 : col + 2'd1;
    assign sh2    = mode ? SHIFT_I2 : SHIFT_F2;

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            s2_in[r] = tbuf[r][s2_sel];
        end
        if (state == FILL) s2_in[3] = s1_val[0];
    end

    dct4_1d #(.IN_W(BUF_W)) u_stage2 (
        .inv (mode),
        .x0  (s2_in[0]),
        .x1  (s2_in[1]),
        .x2  (s2_in[2]),
        .x3  (s2_in[3]),
        .y0  (s2_raw[0]),
        .y1  (s2_raw[1]),
        .y2  (s2_raw[2]),
        .y3  (s2_raw[3])
    );

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            s2_val[i] = WIDTH_Y'(saturate(round_shift(EXT_W'(s2_raw[i]), sh2), WIDTH_Y));
        end
    end

    // ---------------- Buffer, counters and output registers ----------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            row  <= 2'd0;
            col  <= 2'd0;
            mode <= 1'b0;
            for (int r = 0; r < 4; r++) begin
                yreg[r] <= '0;
                for (int c = 0; c < 4; c++) tbuf[r][c] <= '0;
            end
        end else begin
            if (in_fire) begin
                for (int c = 0; c < 4; c++) tbuf[row][c] <= s1_val[c];
                row <= row + 2'd1;
                if (row == 2'd0) mode <= inv;
                if (row == 2'd3) begin
                    for (int i = 0; i < 4; i++) yreg[i] <= s2_val[i];
                end
            end
            if (out_fire) begin
                col <= col + 2'd1;
                // After the last column the outputs simply hold.
                if (col != 2'd3) begin
                    for (int i = 0; i < 4; i++) yreg[i] <= s2_val[i];
                end
            end
        end
    end

    assign y0 = yreg[0];
    assign y1 = yreg[1];
    assign y2 = yreg[2];
    assign y3 = yreg[3];

endmodule

// File: tb/tb_dct4_2d.sv
module tb_dct4_2d;

    typedef logic [3:0][3:0][15:0] blk_t;   // [row or beat][element]

    typedef struct packed {
        logic inv;
        blk_t x;    // x[r][j]  : input row r, sample j
        blk_t ey;   // ey[c][k] : output beat c, y_k
    } vec_t;

    localparam int NV = 24;

    logic clk = 1'b0;
    logic rst_b = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic inv = 1'b0;
    logic signed [15:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic signed [15:0] y0, y1, y2, y3;

    int n_chk = 0;
    int n_fail = 0;

    vec_t tbl [NV];

    always #5 clk = ~clk;

    dct4_2d dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inv       (inv),
        .x0        (x0),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y0        (y0),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- Reference model (matrix form) ----------------
    function automatic longint rnd(input longint v, input int s);
        if (s <= 0) return v;
        return (v + (longint'(1) << (s - 1))) >>> s;
    endfunction

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Forward: y = M x.  Inverse: y = M^T x.
    function automatic blk_t model(input blk_t x, input logic md);
        longint m [4][4];
        longint t [4][4];
        longint acc;
        int s1, s2;
        blk_t res;
        m[0] = '{64, 64, 64, 64};
        m[1] = '{83, 36, -36, -83};
        m[2] = '{64, -64, -64, 64};
        m[3] = '{36, -83, 83, -36};
        s1 = md ? 7 : 1;
        s2 = md ? 12 : 8;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                acc = 0;
                for (int j = 0; j < 4; j++)
                    acc += (md ? m[j][k] : m[k][j]) * longint'($signed(x[r][j]));
                t[r][k] = sat16(rnd(acc, s1));
            end
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++) begin
                acc = 0;
                for (int r = 0; r < 4; r++)
                    acc += (md ? m[r][k] : m[k][r]) * t[r][c];
                res[c][k] = 16'(sat16(rnd(acc, s2)));
            end
        return res;
    endfunction

    // ---------------- Drivers ----------------
    // All driving and sampling happens on the falling edge.
    task automatic send_rows(input blk_t x, input logic md, input int nrows);
        int g;
        for (int r = 0; r < nrows; r++) begin
            in_valid = 1'b1;
            inv = (r == 0) ? md : ~md;   // inv after row 0 must be ignored
            x0 = x[r][0];
            x1 = x[r][1];
            x2 = x[r][2];
            x3 = x[r][3];
            g = 0;
            while (!in_ready && g < 20) begin
                @(negedge clk);
                g++;
            end
            if (!in_ready) check("in_ready timeout", 64'(in_ready), 64'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (nrows == 4) check("latency out_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic recv_block(input blk_t ey, input int stall_col, input int stall_len,
                              input bit rand_stall);
        int g;
        for (int c = 0; c < 4; c++) begin
            out_ready = 1'b0;
            g = 0;
            while (!out_valid && g < 20) begin
                @(negedge clk);
                g++;
            end
            if (!out_valid) check("out_valid timeout", 64'(out_valid), 64'd1);
            if (c == stall_col) begin
                // Back-pressure with junk rows offered: nothing may move.
                for (int s = 0; s < stall_len; s++) begin
                    in_valid = 1'b1;
                    x0 = 16'sh7fff; x1 = -16'sd1; x2 = 16'sh1234; x3 = -16'sd300;
                    check("stall y hold", {y0, y1, y2, y3},
                          {ey[c][0], ey[c][1], ey[c][2], ey[c][3]});
                    check("stall in_ready", 64'(in_ready), 64'd0);
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            if (rand_stall) begin
                g = 0;
                while ($urandom_range(0, 2) == 0 && g < 4) begin
                    check("rand stall y hold", {y0, y1, y2, y3},
                          {ey[c][0], ey[c][1], ey[c][2], ey[c][3]});
                    @(negedge clk);
                    g++;
                end
            end
            out_ready = 1'b1;
            check($sformatf("beat %0d", c), {y0, y1, y2, y3},
                  {ey[c][0], ey[c][1], ey[c][2], ey[c][3]});
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("out_valid drop", 64'(out_valid), 64'd0);
        check("in_ready back", 64'(in_ready), 64'd1);
    endtask

    task automatic pulse_reset();
        rst_b = 1'b0;
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset y", {y0, y1, y2, y3}, 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        blk_t xb, eb, junk;
        int g;

        // ---------------- Vector table ----------------
        // DC 10, forward
        for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) xb[r][j] = 16'd10;
        eb = '0; eb[0][0] = 16'd1280;
        tbl[0] = '{inv: 1'b0, x: xb, ey: eb};
        // Inverse impulse at row 0 sample 0
        xb = '0; xb[0][0] = 16'd64;
        for (int c = 0; c < 4; c++) for (int k = 0; k < 4; k++) eb[c][k] = 16'd1;
        tbl[1] = '{inv: 1'b1, x: xb, ey: eb};
        // DC 255, forward: largest DC without saturation
        for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) xb[r][j] = 16'd255;
        eb = '0; eb[0][0] = 16'd32640;
        tbl[2] = '{inv: 1'b0, x: xb, ey: eb};
        // Random blocks, half full-range (saturating), half small
        for (int i = 3; i < NV; i++) begin
            for (int r = 0; r < 4; r++)
                for (int j = 0; j < 4; j++)
                    xb[r][j] = (i % 2 == 0) ? 16'($urandom)
                                            : 16'($signed($urandom_range(0, 1023)) - 512);
            tbl[i].inv = 1'($urandom_range(0, 1));
            tbl[i].x   = xb;
            tbl[i].ey  = model(xb, tbl[i].inv);
        end

        // ---------------- Power-on reset ----------------
        #1 rst_b = 1'b0;
        repeat (2) @(negedge clk);
        check("por out_valid", 64'(out_valid), 64'd0);
        check("por in_ready", 64'(in_ready), 64'd1);
        check("por y", {y0, y1, y2, y3}, 64'd0);
        rst_b = 1'b1;
        @(negedge clk);

        // ---------------- Table run ----------------
        for (int i = 0; i < NV; i++) begin
            send_rows(tbl[i].x, tbl[i].inv, 4);
            recv_block(tbl[i].ey, (i == 0 || i == 3) ? 1 : -1, 5, i >= 3);
        end

        // ---------------- Reset mid-FILL ----------------
        for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) junk[r][j] = 16'sd1000 + 16'(r * 4 + j);
        send_rows(junk, 1'b1, 2);
        pulse_reset();
        send_rows(tbl[0].x, 1'b0, 4);
        recv_block(tbl[0].ey, -1, 0, 1'b0);

        // ---------------- Reset mid-DRAIN ----------------
        send_rows(tbl[5].x, tbl[5].inv, 4);
        g = 0;
        while (!out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        out_ready = 1'b1;
        check("pre-reset beat 0", {y0, y1, y2, y3},
              {tbl[5].ey[0][0], tbl[5].ey[0][1], tbl[5].ey[0][2], tbl[5].ey[0][3]});
        @(negedge clk);
        out_ready = 1'b0;
        pulse_reset();
        send_rows(tbl[1].x, 1'b1, 4);
        recv_block(tbl[1].ey, -1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dct4_2d.md
DCT4_2D -- requirements
Module: dct4_2d

Interface
REQ-001 SHALL have parameter WIDTH_X, default 16: signed width of each input sample or coefficient.
REQ-002 SHALL have parameter WIDTH_Y, default 16: signed width of each output value.
REQ-003 SHALL have parameters SHIFT_F1/SHIFT_F2, defaults 1/8: forward stage-1 and stage-2 right shifts.
REQ-004 SHALL have parameters SHIFT_I1/SHIFT_I2, defaults 7/12: inverse stage-1 and stage-2 right shifts.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_b, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have ports in_valid (input, 1) and in_ready (output, 1): input beat handshake.
REQ-009 SHALL have port inv, input, 1 bit: 0 = forward DCT, 1 = inverse DCT; sampled on the first beat of a block.
REQ-010 SHALL have ports x0..x3, input, WIDTH_X signed each: one row of the 4x4 input block.
REQ-011 SHALL have ports out_valid (output, 1) and out_ready (input, 1): output beat handshake.
REQ-012 SHALL have ports y0..y3, output, WIDTH_Y signed each: one column of the 4x4 result, y0 = row 0.

Function
REQ-013 SHALL transfer a beat only on a rising edge where valid and ready are both 1.
REQ-014 SHALL use FSM states FILL and DRAIN; reset enters FILL.
REQ-015 In FILL: in_ready=1, out_valid=0; each accepted row r (r=0..3, row counter) passes through the 1D transform and is written to transpose buffer row r.
REQ-016 Forward 1D transform: a0=x0+x3, a1=x1+x2, b0=x0-x3, b1=x1-x2; y0=64a0+64a1, y1=83b0+36b1, y2=64a0-64a1, y3=36b0-83b1.
REQ-017 Inverse 1D transform: E0=64(x0+x2), E1=64(x0-x2), O0=83x1+36x3, O1=36x1-83x3; y0=E0+O0, y1=E1+O1, y2=E1-O1, y3=E0-O0.
REQ-018 Stage-1 results SHALL be rounded as (v + 2^(s-1)) >>> s, using SHIFT_F1 or SHIFT_I1, saturated to signed 16 bits, then stored.
REQ-019 Internal sums SHALL be at least WIDTH+9 bits wide, so that no overflow occurs before rounding.
REQ-020 The mode captured on row 0 SHALL apply to the whole block; inv on rows 1..3 is ignored.
REQ-021 On acceptance of row 3, the FSM SHALL enter DRAIN on the next edge, with the y registers loaded with column 0 of the stage-2 transform.
- Latency: out_valid=1 one cycle after the row-3 handshake.
REQ-022 Stage 2 SHALL apply the same 1D transform (same mode) to buffer column c, rounded with SHIFT_F2/SHIFT_I2 and saturated to WIDTH_Y.
REQ-023 In DRAIN: in_ready=0, out_valid=1; on each output handshake the column counter increments and the y registers load the next column.
- After the column-3 handshake: the FSM returns to FILL and out_valid drops on the next edge.
REQ-024 While out_valid=1 and out_ready=0, y0..y3 SHALL hold stable.
REQ-025 in_valid during DRAIN SHALL be ignored, with no buffer write.
REQ-026 Counters SHALL wrap from 3 to 0 at block end.
REQ-027 Throughput SHALL be one block per 8 handshake cycles minimum (no overlap of FILL and DRAIN).

Reset
REQ-028 rst_b=0 SHALL immediately force: state=FILL, both counters=0, captured mode=0, out_valid=0, y0..y3=0, all buffer entries=0.
REQ-029 Reset mid-FILL or mid-DRAIN SHALL discard the partial block; the next accepted row is row 0.

Structure
REQ-030 Package dct_pkg SHALL hold coefficients 64/83/36, default shift values and the FILL/DRAIN state enum.
REQ-031 The 1D transform SHALL be a combinational sub-module dct4_1d with an inv select, instantiated once for stage 1 and once for stage 2.

Verification
REQ-032 Forward, all 16 samples = 10 -> beat 0 y=(1280,0,0,0); beats 1..3 all zero.
REQ-033 Inverse, row 0=(64,0,0,0), rows 1..3 zero -> all four beats y=(1,1,1,1).
REQ-034 Forward, all 16 samples = 255 -> beat 0 y0=32640; all other outputs 0; no saturation.
REQ-035 out_ready=0 for 5 cycles at column 1 -> y stable, in_ready=0 throughout; remaining columns correct afterward.
REQ-036 rst_b pulsed after 2 rows accepted, then 4 fresh DC-10 rows -> beat 0 y0=1280, with no residue from the discarded rows.
